// File: rtl/fir_tdm_if.sv
// Sample/coefficient bus of the time-multiplexed FIR: coefficient write port,
// valid/ready sample input and the held result with its one-cycle valid pulse.
interface fir_tdm_if #(
  parameter int D_BITS = 16,
  parameter int M_BITS = 16,
  parameter int N_TAPS = 32
);
  localparam int CA_BITS = $clog2(N_TAPS);
  localparam int O_BITS  = D_BITS + M_BITS + $clog2(N_TAPS);

  logic                      coef_wr_i;
  logic [CA_BITS-1:0]        coef_addr_i;
  logic signed [M_BITS-1:0]  coef_data_i;
  logic                      x_valid_i;
  logic                      x_ready_o;
  logic signed [D_BITS-1:0]  x_i;
  logic                      y_valid_o;
  logic signed [O_BITS-1:0]  y_o;

  modport master (
    output coef_wr_i, coef_addr_i, coef_data_i, x_valid_i, x_i,
    input  x_ready_o, y_valid_o, y_o
  );

  modport slave (
    input  coef_wr_i, coef_addr_i, coef_data_i, x_valid_i, x_i,
    output x_ready_o, y_valid_o, y_o
  );
endinterface

// File: rtl/fir_tdm.sv
// Time-multiplexed FIR: one shared multiplier/accumulator, programmable taps,
// optional symmetric pre-adder, valid/ready sample input.
//
// state | meaning
// IDLE  | ready for a sample; coefficient writes accepted
// MAC   | one product per cycle into the accumulator, K cycles
// DONE  | y_valid_o pulse, result held on y_o
module fir_tdm #(
  parameter int D_BITS = 16,
  parameter int M_BITS = 16,
  parameter int N_TAPS = 32,
  parameter int SYM    = 1
) (
  input logic     clk_i,
  input logic     rst_i,
  fir_tdm_if.slave bus
);
  localparam int K        = (SYM != 0) ? N_TAPS / 2 : N_TAPS;
  localparam int CA_BITS  = $clog2(N_TAPS);
  localparam int O_BITS   = D_BITS + M_BITS + $clog2(N_TAPS);
  localparam int IDX_BITS = (K > 1) ? $clog2(K) : 1;
  localparam int P_BITS   = D_BITS + M_BITS + 1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(K - 1);
  localparam logic [CA_BITS:0]    K_LIM    = (CA_BITS + 1)'(K);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                   state_q;
  logic                     x_ready_q;
  logic                     y_valid_q;
  logic signed [O_BITS-1:0] y_q;
  logic signed [O_BITS-1:0] acc_q;
  logic signed [O_BITS-1:0] acc_d;
  logic [IDX_BITS-1:0]      idx_q;
  logic signed [D_BITS-1:0] d_q [N_TAPS];
  logic signed [M_BITS-1:0] c_q [K];

  logic signed [D_BITS-1:0] tap_a;
  logic signed [D_BITS:0]   pre;
  logic signed [M_BITS-1:0] c_sel;
  logic signed [P_BITS-1:0] prod;
  logic                     coef_we;

  assign tap_a = d_q[CA_BITS'(idx_q)];
  assign c_sel = c_q[idx_q];

  // Symmetric mode folds tap idx with its mirror before the single multiply.
  if (SYM != 0) begin : g_sym
    localparam logic [CA_BITS-1:0] TAP_LAST = CA_BITS'(N_TAPS - 1);
    logic [CA_BITS-1:0]       mirror;
    logic signed [D_BITS-1:0] tap_b;
    assign mirror = TAP_LAST - CA_BITS'(idx_q);
    assign tap_b  = d_q[mirror];
    assign pre    = {tap_a[D_BITS-1], tap_a} + {tap_b[D_BITS-1], tap_b};
  end else begin : g_gen
    assign pre = {tap_a[D_BITS-1], tap_a};
  end

  assign prod  = c_sel * pre;
  assign acc_d = acc_q + {{(O_BITS - P_BITS){prod[P_BITS-1]}}, prod};

  assign coef_we = (state_q == IDLE) && bus.coef_wr_i &&
                   ({1'b0, bus.coef_addr_i} < K_LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      x_ready_q <= 1'b1;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      for (int k = 0; k < N_TAPS; k++) d_q[k] <= '0;
      for (int k = 0; k < K; k++)      c_q[k] <= '0;
    end else begin
      y_valid_q <= 1'b0;
      if (coef_we) c_q[bus.coef_addr_i[IDX_BITS-1:0]] <= bus.coef_data_i;
      case (state_q)
        IDLE: begin
          if (bus.x_valid_i) begin
            d_q[0] <= bus.x_i;
            for (int k = 1; k < N_TAPS; k++) d_q[k] <= d_q[k-1];
            acc_q     <= '0;
            idx_q     <= '0;
            x_ready_q <= 1'b0;
            state_q   <= MAC;
          end
        end
        MAC: begin
          if (idx_q == IDX_LAST) begin
            y_q       <= acc_d;
            y_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            acc_q <= acc_d;
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          x_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          x_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_ready_o = x_ready_q;
  assign bus.y_valid_o = y_valid_q;
  assign bus.y_o       = y_q;
endmodule
